window_read_addr_gen: RTL and testbench
=======================================

# window_read_addr_gen

Parametrised read-address generator for the input-feature (IF) scratchpad of the convolution datapath. For one input row it walks every filter window, tap by tap, and emits one circular-buffer read address per accepted beat. Stride, filter size, dilation, row length and base pointer are programmed per row. The block sits between the row controller (start/abort) and the IF buffer read port (valid/ready), and flags window and row boundaries for the MAC array.

## Interface
- ADDR_WIDTH, 8, read-pointer width; addresses wrap modulo 2^ADDR_WIDTH
- SIZE_WIDTH, 8, width of filter_size and row_len
- STRIDE_WIDTH, 3, width of stride
- DIL_WIDTH, 3, width of dilation

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a row; sampled in IDLE only
- abort  in  1  cancel the current row; honoured in RUN/DONE
- base_ptr  in  ADDR_WIDTH  buffer address of row element 0
- row_len  in  SIZE_WIDTH  elements in row
- filter_size  in  SIZE_WIDTH  taps per window (1-based)
- stride  in  STRIDE_WIDTH  window-start step, in elements
- dilation  in  DIL_WIDTH  tap spacing, in elements
- addr  out  ADDR_WIDTH  read address
- addr_valid  out  1  addr is valid
- addr_ready  in  1  consumer accepts addr this cycle
- window_last  out  1  current beat is the last tap of a window
- row_last  out  1  current beat is the last beat of the row
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at row completion
- cfg_err  out  1  one-cycle pulse with done when the configuration is illegal

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start:
  - Latch all config inputs.
  - Clear win_start and tap.
  - Compute span = (filter_size-1)*dilation + 1 at SIZE_WIDTH+DIL_WIDTH+1 bits.
  - Illegal config (filter_size==0, stride==0, dilation==0, or span>row_len): go to DONE with cfg_err. No beat is emitted.
  - Otherwise go to RUN.
- RUN:
  - addr_valid=1.
  - addr = (base + win_start + tap*dilation) mod 2^ADDR_WIDTH. Compute internally at full width, then truncate.
- Beat accepted (addr_valid && addr_ready):
  - If tap < filter_size-1: tap += 1.
  - Otherwise (window_last=1): tap <= 0, win_start += stride.
  - If the next window_start + span > row_len, that beat also asserts row_last and the FSM goes to DONE.
- No accepted beat: addr and flags hold, and no state changes.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- abort in RUN or DONE: go to IDLE next cycle. It overrides a simultaneous accept. No done pulse.
- start outside IDLE is ignored. Latched config never changes mid-row.
- window_last and row_last are combinational from state and are qualified by addr_valid.

## Timing
- Reset values: addr=0, addr_valid=0, window_last=0, row_last=0, busy=0, done=0, cfg_err=0. State is IDLE, and all counters are 0.
- start sampled at edge N: addr_valid=1 and the first address are visible after edge N, so valid is asserted in cycle N+1.
- Throughput is 1 address per cycle while addr_ready=1.
- Total beats per row = W*filter_size, where W = floor((row_len-span)/stride)+1.
- Last beat accepted at edge M: done=1 in cycle M+1 and busy=0 in cycle M+2. A new start is accepted at the earliest in cycle M+2.
- Illegal config: done=cfg_err=1 in cycle N+1.
- rst asserted mid-row clears the FSM immediately (asynchronously), regardless of the handshake.

## Test plan
- Basic row: base 0, row_len 8, filter 3, stride 1, dil 1, ready held 1.
  - Addresses: 0,1,2, 1,2,3, … , 5,6,7 (18 beats).
  - window_last on every 3rd beat; row_last on beat 18; done in the next cycle.
- Stride 2 (otherwise as above):
  - Windows start at 0, 2, 4; the window at 6 is not generated.
  - 9 beats; row_last on address 6.
- Dilation 2, filter 3, row_len 8, stride 1 (span 5):
  - Addresses: 0,2,4 / 1,3,5 / 2,4,6 / 3,5,7.
- Wrap: ADDR_WIDTH 8, base 254, row_len 4, filter 3, stride 1.
  - Addresses: 254,255,0 / 255,0,1.
- Backpressure and abort: toggle addr_ready randomly during the basic row.
  - addr and flags are stable while ready=0, and the sequence is identical to the basic row.
  - abort on beat 7: busy=0 next cycle, no done pulse; the next start restarts at base.
- Illegal config: filter_size 0, or span 9 with row_len 8.
  - Zero valid beats; done=cfg_err=1 one cycle after start.
- Reset: assert rst mid-row; all outputs go to 0 immediately.

Source files
------------

// File: rtl/window_read_addr_gen.sv
// Read-address generator for the IF scratchpad: walks every filter
// window of one input row, tap by tap, one circular-buffer address per beat.
module window_read_addr_gen #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SIZE_WIDTH   = 8,
  parameter int STRIDE_WIDTH = 3,
  parameter int DIL_WIDTH    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [ADDR_WIDTH-1:0]   i_base_ptr,
  input  logic [SIZE_WIDTH-1:0]   i_row_len,
  input  logic [SIZE_WIDTH-1:0]   i_filter_size,
  input  logic [STRIDE_WIDTH-1:0] i_stride,
  input  logic [DIL_WIDTH-1:0]    i_dilation,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic                    o_addr_valid,
  input  logic                    i_addr_ready,
  output logic                    o_window_last,
  output logic                    o_row_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_cfg_err
);

  localparam int SPAN_W = SIZE_WIDTH + DIL_WIDTH + 1;
  localparam int WS_W   = SIZE_WIDTH + STRIDE_WIDTH + 1;
  localparam int CMP_W  = SIZE_WIDTH + DIL_WIDTH + STRIDE_WIDTH + 2;
  localparam int PROD_W = SIZE_WIDTH + DIL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0]   r_base;
  logic [SIZE_WIDTH-1:0]   r_row_len;
  logic [SIZE_WIDTH-1:0]   r_fs;
  logic [STRIDE_WIDTH-1:0] r_stride;
  logic [DIL_WIDTH-1:0]    r_dil;
  logic [SPAN_W-1:0]       r_span;
  logic [WS_W-1:0]         r_win_start;
  logic [SIZE_WIDTH-1:0]   r_tap;
  logic                    r_cfg_err;

  logic [SIZE_WIDTH-1:0] w_fs_m1;
  logic [SPAN_W-1:0]     w_span_in;
  logic                  w_cfg_bad;
  logic                  w_run;
  logic                  w_last_tap;
  logic [WS_W-1:0]       w_next_ws;
  logic                  w_row_end;
  logic                  w_accept;
  logic                  w_start;
  logic [PROD_W-1:0]     w_off;
  logic [ADDR_WIDTH-1:0] w_addr;

  // span is only meaningful for filter_size>0; zero is rejected anyway
  assign w_fs_m1   = i_filter_size - SIZE_WIDTH'(1);
  assign w_span_in = SPAN_W'(w_fs_m1) * SPAN_W'(i_dilation)
                   + SPAN_W'(1);
  assign w_cfg_bad = (i_filter_size == '0) ||
                     (i_stride == '0) ||
                     (i_dilation == '0) ||
                     (w_span_in > SPAN_W'(i_row_len));

  assign w_run      = (r_state == S_RUN);
  assign w_start    = (r_state == S_IDLE) && i_start;
  assign w_last_tap = (r_tap == r_fs - SIZE_WIDTH'(1));
  assign w_next_ws  = r_win_start + WS_W'(r_stride);
  assign w_row_end  = (CMP_W'(w_next_ws) + CMP_W'(r_span))
                    > CMP_W'(r_row_len);
  assign w_accept   = w_run && i_addr_ready && !i_abort;

  // modular sum: truncating each term first gives the same low bits
  assign w_off  = PROD_W'(r_tap) * PROD_W'(r_dil);
  assign w_addr = r_base + ADDR_WIDTH'(r_win_start)
                + ADDR_WIDTH'(w_off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_cfg_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_addr_ready && w_last_tap && w_row_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_row_len   <= '0;
      r_fs        <= '0;
      r_stride    <= '0;
      r_dil       <= '0;
      r_span      <= '0;
      r_win_start <= '0;
      r_tap       <= '0;
      r_cfg_err   <= 1'b0;
    end else if (w_start) begin
      r_base      <= i_base_ptr;
      r_row_len   <= i_row_len;
      r_fs        <= i_filter_size;
      r_stride    <= i_stride;
      r_dil       <= i_dilation;
      r_span      <= w_span_in;
      r_win_start <= '0;
      r_tap       <= '0;
      r_cfg_err   <= w_cfg_bad;
    end else if (w_accept) begin
      if (w_last_tap) begin
        r_tap       <= '0;
        r_win_start <= w_next_ws;
      end else begin
        r_tap <= r_tap + SIZE_WIDTH'(1);
      end
    end
  end

  assign o_addr        = w_run ? w_addr : '0;
  assign o_addr_valid  = w_run;
  assign o_window_last = w_run && w_last_tap;
  assign o_row_last    = w_run && w_last_tap && w_row_end;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_cfg_err     = (r_state == S_DONE) && r_cfg_err;

endmodule

// File: tb/tb_window_read_addr_gen.sv
// Bench for window_read_addr_gen: directed table, corner sequences and
// random rows against a window/tap enumeration model.
module tb_window_read_addr_gen;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_abort;
  logic [7:0] i_base_ptr;
  logic [7:0] i_row_len;
  logic [7:0] i_filter_size;
  logic [2:0] i_stride;
  logic [2:0] i_dilation;
  logic [7:0] o_addr;
  logic       o_addr_valid;
  logic       i_addr_ready;
  logic       o_window_last;
  logic       o_row_last;
  logic       o_busy;
  logic       o_done;
  logic       o_cfg_err;

  window_read_addr_gen dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_base_ptr   (i_base_ptr),
    .i_row_len    (i_row_len),
    .i_filter_size(i_filter_size),
    .i_stride     (i_stride),
    .i_dilation   (i_dilation),
    .o_addr       (o_addr),
    .o_addr_valid (o_addr_valid),
    .i_addr_ready (i_addr_ready),
    .o_window_last(o_window_last),
    .o_row_last   (o_row_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cfg_err    (o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int wl;
    int rl;
  } beat_t;

  typedef struct {
    int base;
    int len;
    int fs;
    int st;
    int dil;
    int beats;
    int first_a;
    int last_a;
    int err;
  } vec_t;

  beat_t exp_q[$];
  int checks;
  int failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Enumerate windows and taps directly from the row geometry.
  task automatic build(input int base, input int len, input int fs,
                       input int st, input int dil, output bit illegal);
    int span;
    int nw;
    beat_t b;
    exp_q.delete();
    span = (fs - 1) * dil + 1;
    illegal = (fs == 0) || (st == 0) || (dil == 0) || (span > len);
    if (!illegal) begin
      nw = (len - span) / st + 1;
      for (int w = 0; w < nw; w++) begin
        for (int t = 0; t < fs; t++) begin
          b.addr = (base + w * st + t * dil) % 256;
          b.wl   = (t == fs - 1) ? 1 : 0;
          b.rl   = (t == fs - 1 && w == nw - 1) ? 1 : 0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic run_row(input int base, input int len, input int fs,
                         input int st, input int dil, input bit rnd,
                         input int abort_at, output int nbeats,
                         output int first_a, output int last_a,
                         output int err_seen);
    bit    illegal;
    bit    stalled;
    bit    finished;
    int    s_addr;
    int    s_wl;
    int    s_rl;
    beat_t e;
    build(base, len, fs, st, dil, illegal);
    nbeats   = 0;
    first_a  = -1;
    last_a   = -1;
    err_seen = 0;
    stalled  = 0;
    finished = 0;
    s_addr   = 0;
    s_wl     = 0;
    s_rl     = 0;
    i_base_ptr    = base[7:0];
    i_row_len     = len[7:0];
    i_filter_size = fs[7:0];
    i_stride      = st[2:0];
    i_dilation    = dil[2:0];
    i_start       = 1'b1;
    @(posedge clk);
    #1;
    i_start       = 1'b0;
    i_base_ptr    = 8'($urandom);
    i_row_len     = 8'($urandom);
    i_filter_size = 8'($urandom);
    i_stride      = 3'($urandom);
    i_dilation    = 3'($urandom);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      i_addr_ready = rnd ? 1'($urandom % 2) : 1'b1;
      i_abort = (abort_at >= 0 && nbeats == abort_at &&
                 o_addr_valid && i_addr_ready);
      @(negedge clk);
      if (cyc == 0) begin
        chk("first_cycle", illegal ? int'(o_done) : int'(o_addr_valid), 1);
      end
      if (i_abort) begin
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_done", int'(o_done), 0);
        chk("abort_valid", int'(o_addr_valid), 0);
        finished = 1;
      end else if (o_done) begin
        err_seen = int'(o_cfg_err);
        chk("cfg_err", int'(o_cfg_err), int'(illegal));
        chk("beats_left", exp_q.size(), 0);
        chk("done_valid", int'(o_addr_valid), 0);
        chk("done_busy", int'(o_busy), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_busy", int'(o_busy), 0);
        chk("done_pulse", int'(o_done), 0);
        finished = 1;
      end else if (exp_q.size() == 0) begin
        chk("done_latency", int'(o_done), 1);
        finished = 1;
      end else if (o_addr_valid) begin
        if (stalled) begin
          chk("stall_addr", int'(o_addr), s_addr);
          chk("stall_wl", int'(o_window_last), s_wl);
          chk("stall_rl", int'(o_row_last), s_rl);
        end
        if (i_addr_ready) begin
          e = exp_q.pop_front();
          chk("addr", int'(o_addr), e.addr);
          chk("window_last", int'(o_window_last), e.wl);
          chk("row_last", int'(o_row_last), e.rl);
          if (nbeats == 0) first_a = int'(o_addr);
          last_a = int'(o_addr);
          nbeats++;
          stalled = 0;
        end else begin
          s_addr  = int'(o_addr);
          s_wl    = int'(o_window_last);
          s_rl    = int'(o_row_last);
          stalled = 1;
        end
      end else begin
        chk("valid_drop", int'(o_addr_valid), 1);
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk);
        #1;
      end
    end
    if (!finished) chk("row_timeout", 0, 1);
    i_addr_ready = 1'b0;
    i_abort      = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int nb, fa, la, er;
    bit il;
    checks   = 0;
    failures = 0;
    vecs[0] = '{0,   8, 3, 1, 1, 18, 0,   7,  0};
    vecs[1] = '{0,   8, 3, 2, 1, 9,  0,   6,  0};
    vecs[2] = '{0,   8, 3, 1, 2, 12, 0,   7,  0};
    vecs[3] = '{254, 4, 3, 1, 1, 6,  254, 1,  0};
    vecs[4] = '{0,   8, 0, 1, 1, 0,  -1,  -1, 1};
    vecs[5] = '{0,   8, 5, 1, 2, 0,  -1,  -1, 1};
    vecs[6] = '{9,   8, 8, 1, 1, 8,  9,   16, 0};

    rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_addr_ready = 1'b0;
    i_base_ptr = '0;
    i_row_len = '0;
    i_filter_size = '0;
    i_stride = '0;
    i_dilation = '0;
    #3;
    chk("rst_addr", int'(o_addr), 0);
    chk("rst_valid", int'(o_addr_valid), 0);
    chk("rst_wl", int'(o_window_last), 0);
    chk("rst_rl", int'(o_row_last), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_err", int'(o_cfg_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_row(vecs[i].base, vecs[i].len, vecs[i].fs, vecs[i].st,
              vecs[i].dil, 1'b0, -1, nb, fa, la, er);
      chk("vec_beats", nb, vecs[i].beats);
      chk("vec_first", fa, vecs[i].first_a);
      chk("vec_last", la, vecs[i].last_a);
      chk("vec_err", er, vecs[i].err);
    end

    run_row(0, 8, 3, 1, 1, 1'b1, -1, nb, fa, la, er);
    chk("bp_beats", nb, 18);

    run_row(0, 8, 3, 1, 1, 1'b1, 6, nb, fa, la, er);
    chk("abort_beats", nb, 6);
    run_row(0, 8, 3, 1, 1, 1'b0, -1, nb, fa, la, er);
    chk("restart_first", fa, 0);
    chk("restart_beats", nb, 18);

    i_base_ptr = 8'd0;
    i_row_len = 8'd8;
    i_filter_size = 8'd3;
    i_stride = 3'd1;
    i_dilation = 3'd1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_addr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", int'(o_addr), 0);
    chk("mid_rst_valid", int'(o_addr_valid), 0);
    chk("mid_rst_wl", int'(o_window_last), 0);
    chk("mid_rst_rl", int'(o_row_last), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_done", int'(o_done), 0);
    chk("mid_rst_err", int'(o_cfg_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_addr_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(o_busy), 0);

    for (int r = 0; r < 40; r++) begin
      int b, l, f, s, d, span, wexp;
      b = $urandom % 256;
      l = 1 + $urandom % 20;
      f = $urandom % 7;
      s = $urandom % 5;
      d = $urandom % 4;
      run_row(b, l, f, s, d, 1'b1, -1, nb, fa, la, er);
      span = (f - 1) * d + 1;
      il = (f == 0) || (s == 0) || (d == 0) || (span > l);
      wexp = il ? 0 : ((l - span) / s + 1) * f;
      chk("rand_beats", nb, wexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
